// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between GPP (port 0) and CP (port 1), with bounded locked bursts.
// Latency: one bubble cycle from a request seen in IDLE to its grant; read data returns 1 cycle after accept.
// Backpressure: a requester waits with gnt low and holds its beat stable; no beat is queued inside the arbiter.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t          state, state_nx;
    logic            last, last_nx;   // port that owned the RAM most recently
    logic [CW-1:0]   cnt, cnt_nx;     // beats taken in the current ownership
    logic [CW-1:0]   cnt_inc;
    logic            accept;
    logic            rd_pend0, rd_pend1;

    assign gnt0    = (state == OWN0) & req0;
    assign gnt1    = (state == OWN1) & req1;
    assign accept  = gnt0 | gnt1;
    assign mem_en  = accept;
    assign owner   = state;
    // Beat count saturates so a long uncontested burst cannot wrap.
    assign cnt_inc = (accept && (cnt != BURST_LIM)) ? cnt + 1'b1 : cnt;

    // Route the accepted beat to the RAM; drive zeros when nothing is accepted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // Ownership next-state: round-robin from IDLE, burst limit only enforced when the other port waits.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (req0 && req1) begin
                    state_nx = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nx = OWN0;
                end else if (req1) begin
                    state_nx = OWN1;
                end
            end
            OWN0: begin
                if (!req0 && !req1) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                    cnt_nx   = '0;
                end else if (req1 && (!req0 || !lock0 || cnt_inc == BURST_LIM)) begin
                    state_nx = OWN1;
                    last_nx  = 1'b0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            OWN1: begin
                if (!req0 && !req1) begin
                    state_nx = IDLE;
                    last_nx  = 1'b1;
                    cnt_nx   = '0;
                end else if (req0 && (!req1 || !lock1 || cnt_inc == BURST_LIM)) begin
                    state_nx = OWN0;
                    last_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Ownership state; last=1 after reset so a contested first grant goes to port 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Read tags follow the issuing port, so a handover never misroutes returning data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 & ~we0;
            rd_pend1 <= gnt1 & ~we1;
        end
    end

    assign rvalid0 = rd_pend0;
    assign rvalid1 = rd_pend1;
    assign rdata0  = rd_pend0 ? mem_rdata : '0;
    assign rdata1  = rd_pend1 ? mem_rdata : '0;

endmodule
